// File: rtl/gt_victim_buffer_if.sv
// Bus bundle for gt_victim_buffer.
//   Insert channel : ins_valid, ins_ready, ins_addr, ins_data, ins_dirty (L1 -> buffer)
//   Lookup channel : lk_valid, lk_addr (request), lk_done, lk_hit, lk_dirty,
//                    lk_line, lk_byte (registered result, one cycle later)
//   Write-back     : wb_valid, wb_ready, wb_addr, wb_data (buffer -> memory)
//
// Handshakes: a transfer happens on a rising clock edge where both valid
// and ready are high. Once raised, wb_valid and its payload hold until that
// transfer happens. ins_valid may be dropped at any time; ins_ready does not
// depend on ins_valid. lk_valid has no ready: every lookup is accepted.
interface gt_victim_buffer_if #(
  parameter int ADDR_BITS = 32,
  parameter int LINE_BITS = 256
) ();
  logic                 ins_valid;
  logic                 ins_ready;
  logic [ADDR_BITS-1:0] ins_addr;
  logic [LINE_BITS-1:0] ins_data;
  logic                 ins_dirty;

  logic                 lk_valid;
  logic [ADDR_BITS-1:0] lk_addr;
  logic                 lk_done;
  logic                 lk_hit;
  logic                 lk_dirty;
  logic [LINE_BITS-1:0] lk_line;
  logic [7:0]           lk_byte;

  logic                 wb_valid;
  logic                 wb_ready;
  logic [ADDR_BITS-1:0] wb_addr;
  logic [LINE_BITS-1:0] wb_data;

  modport master (
    output ins_valid, ins_addr, ins_data, ins_dirty, lk_valid, lk_addr, wb_ready,
    input  ins_ready, lk_done, lk_hit, lk_dirty, lk_line, lk_byte,
           wb_valid, wb_addr, wb_data
  );

  modport slave (
    input  ins_valid, ins_addr, ins_data, ins_dirty, lk_valid, lk_addr, wb_ready,
    output ins_ready, lk_done, lk_hit, lk_dirty, lk_line, lk_byte,
           wb_valid, wb_addr, wb_data
  );
endinterface

// File: rtl/gt_victim_buffer.sv
// Fully-associative victim buffer between L1 data cache and main memory.
// True-LRU replacement with per-entry ages (0 = MRU), per-line dirty bits,
// a one-deep write-back register for dirty victims, and exclusive (swap on
// hit) or inclusive (touch on hit) lookup.
// Ports:
//   CLK  - clock, all state on rising edge
//   RST  - synchronous active-high reset
//   vb   - gt_victim_buffer_if.slave: insert, lookup and write-back channels
module gt_victim_buffer #(
  parameter int ADDR_BITS   = 32,
  parameter int LINE_BITS   = 256,
  parameter int OFFSET_BITS = 5,
  parameter int ENTRIES     = 4,
  parameter bit EXCLUSIVE   = 1'b1
) (
  input  logic              CLK,
  input  logic              RST,
  gt_victim_buffer_if.slave vb
);
  localparam int TAG_BITS = ADDR_BITS - OFFSET_BITS;
  localparam int AGE_BITS = $clog2(ENTRIES);
  localparam int BYTES    = LINE_BITS / 8;

  typedef logic [AGE_BITS-1:0] idx_t;

  // Entry storage
  logic                 valid_q [ENTRIES];
  logic                 valid_d [ENTRIES];
  logic                 dirty_q [ENTRIES];
  logic                 dirty_d [ENTRIES];
  logic [TAG_BITS-1:0]  tag_q   [ENTRIES];
  logic [TAG_BITS-1:0]  tag_d   [ENTRIES];
  logic [LINE_BITS-1:0] data_q  [ENTRIES];
  logic [LINE_BITS-1:0] data_d  [ENTRIES];
  idx_t                 age_q   [ENTRIES];
  idx_t                 age_d   [ENTRIES];

  // Write-back register
  logic                 wb_valid_q, wb_valid_d;
  logic [ADDR_BITS-1:0] wb_addr_q,  wb_addr_d;
  logic [LINE_BITS-1:0] wb_data_q,  wb_data_d;

  // Registered lookup result
  logic                 lk_done_q,  lk_done_d;
  logic                 lk_hit_q,   lk_hit_d;
  logic                 lk_dirty_q, lk_dirty_d;
  logic [LINE_BITS-1:0] lk_line_q,  lk_line_d;
  logic [7:0]           lk_byte_q,  lk_byte_d;

  logic [TAG_BITS-1:0]    lk_tag, ins_tag;
  logic [OFFSET_BITS-1:0] lk_off;
  logic                   ins_fire;
  logic                   unused_ins_offset;

  assign lk_tag   = vb.lk_addr[ADDR_BITS-1:OFFSET_BITS];
  assign lk_off   = vb.lk_addr[OFFSET_BITS-1:0];
  assign ins_tag  = vb.ins_addr[ADDR_BITS-1:OFFSET_BITS];
  assign ins_fire = vb.ins_valid && !wb_valid_q;
  // The insert address is a line address; its offset bits carry nothing.
  assign unused_ins_offset = ^vb.ins_addr[OFFSET_BITS-1:0];

  // Associative search over pre-edge state.
  logic lk_hit_any, ins_hit_any, free_any;
  idx_t lk_idx, ins_idx, free_idx, victim_idx;

  always_comb begin : search
    lk_hit_any  = 1'b0;
    lk_idx      = '0;
    ins_hit_any = 1'b0;
    ins_idx     = '0;
    free_any    = 1'b0;
    free_idx    = '0;
    victim_idx  = '0;
    // Descending scan so the lowest-index free entry is the one kept.
    for (int i = ENTRIES - 1; i >= 0; i--) begin
      if (valid_q[i] && tag_q[i] == lk_tag) begin
        lk_hit_any = 1'b1;
        lk_idx     = idx_t'(i);
      end
      if (valid_q[i] && tag_q[i] == ins_tag) begin
        ins_hit_any = 1'b1;
        ins_idx     = idx_t'(i);
      end
      if (!valid_q[i]) begin
        free_any = 1'b1;
        free_idx = idx_t'(i);
      end
      // Only consulted when full, where ages are 0..ENTRIES-1.
      if (valid_q[i] && age_q[i] == idx_t'(ENTRIES - 1)) begin
        victim_idx = idx_t'(i);
      end
    end
  end

  logic lk_hit_now, lk_inval, lk_touch;
  assign lk_hit_now = vb.lk_valid && lk_hit_any;
  // A same-cycle insert of the looked-up tag keeps the entry alive.
  assign lk_inval = lk_hit_now && EXCLUSIVE && !(ins_fire && ins_tag == lk_tag);
  assign lk_touch = lk_hit_now && !EXCLUSIVE;

  idx_t place_idx;
  idx_t old_age;

  always_comb begin : next_state
    valid_d    = valid_q;
    dirty_d    = dirty_q;
    tag_d      = tag_q;
    data_d     = data_q;
    age_d      = age_q;
    wb_valid_d = wb_valid_q;
    wb_addr_d  = wb_addr_q;
    wb_data_d  = wb_data_q;
    place_idx  = '0;
    old_age    = '0;

    if (wb_valid_q && vb.wb_ready) begin
      wb_valid_d = 1'b0;
    end

    // Lookup effect first; the insert is then applied on top of it.
    if (lk_inval) begin
      valid_d[lk_idx] = 1'b0;
      dirty_d[lk_idx] = 1'b0;
      for (int i = 0; i < ENTRIES; i++) begin
        if (valid_q[i] && age_q[i] > age_q[lk_idx]) begin
          age_d[i] = age_q[i] - idx_t'(1);
        end
      end
      age_d[lk_idx] = '0;
    end else if (lk_touch) begin
      for (int i = 0; i < ENTRIES; i++) begin
        if (valid_q[i] && age_q[i] < age_q[lk_idx]) begin
          age_d[i] = age_q[i] + idx_t'(1);
        end
      end
      age_d[lk_idx] = '0;
    end

    if (ins_fire) begin
      // Placement is chosen from pre-edge state.
      if (ins_hit_any) begin
        place_idx = ins_idx;
      end else if (free_any) begin
        place_idx = free_idx;
      end else begin
        place_idx = victim_idx;
      end

      // A victim already invalidated by this cycle's lookup is not written back.
      if (!ins_hit_any && !free_any && valid_d[place_idx] && dirty_q[place_idx]) begin
        wb_valid_d = 1'b1;
        wb_addr_d  = {tag_q[place_idx], {OFFSET_BITS{1'b0}}};
        wb_data_d  = data_q[place_idx];
      end

      if (valid_d[place_idx]) begin
        old_age = age_d[place_idx];
        for (int i = 0; i < ENTRIES; i++) begin
          if (idx_t'(i) != place_idx && valid_d[i] && age_d[i] < old_age) begin
            age_d[i] = age_d[i] + idx_t'(1);
          end
        end
      end else begin
        // New occupant: every resident line ages by one.
        for (int i = 0; i < ENTRIES; i++) begin
          if (valid_d[i]) begin
            age_d[i] = age_d[i] + idx_t'(1);
          end
        end
      end

      dirty_d[place_idx] = ins_hit_any ? (dirty_q[place_idx] | vb.ins_dirty) : vb.ins_dirty;
      valid_d[place_idx] = 1'b1;
      age_d[place_idx]   = '0;
      tag_d[place_idx]   = ins_tag;
      data_d[place_idx]  = vb.ins_data;
    end
  end

  always_comb begin : lookup_result
    lk_done_d  = vb.lk_valid;
    lk_hit_d   = lk_hit_now;
    lk_dirty_d = lk_hit_now ? dirty_q[lk_idx] : 1'b0;
    lk_line_d  = lk_hit_now ? data_q[lk_idx] : '0;
    lk_byte_d  = '0;
    for (int b = 0; b < BYTES; b++) begin
      if (lk_off == OFFSET_BITS'(b)) begin
        lk_byte_d = lk_line_d[b*8 +: 8];
      end
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      for (int i = 0; i < ENTRIES; i++) begin
        valid_q[i] <= 1'b0;
        dirty_q[i] <= 1'b0;
        tag_q[i]   <= '0;
        data_q[i]  <= '0;
        age_q[i]   <= '0;
      end
      wb_valid_q <= 1'b0;
      wb_addr_q  <= '0;
      wb_data_q  <= '0;
      lk_done_q  <= 1'b0;
      lk_hit_q   <= 1'b0;
      lk_dirty_q <= 1'b0;
      lk_line_q  <= '0;
      lk_byte_q  <= '0;
    end else begin
      valid_q    <= valid_d;
      dirty_q    <= dirty_d;
      tag_q      <= tag_d;
      data_q     <= data_d;
      age_q      <= age_d;
      wb_valid_q <= wb_valid_d;
      wb_addr_q  <= wb_addr_d;
      wb_data_q  <= wb_data_d;
      lk_done_q  <= lk_done_d;
      lk_hit_q   <= lk_hit_d;
      lk_dirty_q <= lk_dirty_d;
      lk_line_q  <= lk_line_d;
      lk_byte_q  <= lk_byte_d;
    end
  end

  assign vb.ins_ready = !wb_valid_q;
  assign vb.lk_done   = lk_done_q;
  assign vb.lk_hit    = lk_hit_q;
  assign vb.lk_dirty  = lk_dirty_q;
  assign vb.lk_line   = lk_line_q;
  assign vb.lk_byte   = lk_byte_q;
  assign vb.wb_valid  = wb_valid_q;
  assign vb.wb_addr   = wb_addr_q;
  assign vb.wb_data   = wb_data_q;
endmodule

// File: tb/tb_gt_victim_buffer.sv
// Testbench for gt_victim_buffer: one inclusive (mode 0) and one exclusive
// (mode 1) instance share the same stimulus. A recency-list reference model
// per mode (MRU at position 0) predicts every output each cycle.
module tb_gt_victim_buffer;
  localparam int AB = 32;
  localparam int LB = 256;
  localparam int OB = 5;
  localparam int E  = 4;
  localparam int TW = AB - OB;

  logic clk;
  logic rst;
  int   n_checks;
  int   n_fail;

  gt_victim_buffer_if #(.ADDR_BITS(AB), .LINE_BITS(LB)) if0 ();
  gt_victim_buffer_if #(.ADDR_BITS(AB), .LINE_BITS(LB)) if1 ();

  gt_victim_buffer #(.ADDR_BITS(AB), .LINE_BITS(LB), .OFFSET_BITS(OB), .ENTRIES(E),
                     .EXCLUSIVE(1'b0)) dut0 (.CLK(clk), .RST(rst), .vb(if0));
  gt_victim_buffer #(.ADDR_BITS(AB), .LINE_BITS(LB), .OFFSET_BITS(OB), .ENTRIES(E),
                     .EXCLUSIVE(1'b1)) dut1 (.CLK(clk), .RST(rst), .vb(if1));

  // ---------------- clock ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- reference model ----------------
  logic [TW-1:0] m_tag   [2][E];
  logic [LB-1:0] m_data  [2][E];
  logic          m_dirty [2][E];
  int            m_cnt   [2];

  logic          e_done  [2];
  logic          e_hit   [2];
  logic          e_dirty [2];
  logic [LB-1:0] e_line  [2];
  logic [7:0]    e_byte  [2];
  logic          e_wbv   [2];
  logic [AB-1:0] e_wba   [2];
  logic [LB-1:0] e_wbd   [2];

  function automatic int m_find(input int m, input logic [TW-1:0] t);
    for (int p = 0; p < m_cnt[m]; p++) begin
      if (m_tag[m][p] == t) return p;
    end
    return -1;
  endfunction

  task automatic m_remove(input int m, input int p);
    for (int k = p; k < m_cnt[m] - 1; k++) begin
      m_tag[m][k]   = m_tag[m][k+1];
      m_data[m][k]  = m_data[m][k+1];
      m_dirty[m][k] = m_dirty[m][k+1];
    end
    m_cnt[m] = m_cnt[m] - 1;
  endtask

  task automatic m_push(input int m, input logic [TW-1:0] t, input logic [LB-1:0] d,
                        input logic dr);
    for (int k = m_cnt[m]; k > 0; k--) begin
      if (k < E) begin
        m_tag[m][k]   = m_tag[m][k-1];
        m_data[m][k]  = m_data[m][k-1];
        m_dirty[m][k] = m_dirty[m][k-1];
      end
    end
    m_tag[m][0]   = t;
    m_data[m][0]  = d;
    m_dirty[m][0] = dr;
    if (m_cnt[m] < E) m_cnt[m] = m_cnt[m] + 1;
  endtask

  task automatic model_step(input int m, input logic r, input logic iv,
                            input logic [AB-1:0] ia, input logic [LB-1:0] id,
                            input logic idr, input logic lv, input logic [AB-1:0] la,
                            input logic wr);
    logic          fire, full, removed, vd, sd;
    logic [TW-1:0] ltag, itag, vt;
    logic [LB-1:0] vdat, sdat, tmp;
    int            lpos, ipos, p;
    if (r) begin
      m_cnt[m] = 0;
      e_done[m] = 1'b0; e_hit[m] = 1'b0; e_dirty[m] = 1'b0;
      e_line[m] = '0;   e_byte[m] = '0;  e_wbv[m] = 1'b0;
      return;
    end
    fire = iv && !e_wbv[m];
    ltag = la[AB-1:OB];
    itag = ia[AB-1:OB];
    lpos = m_find(m, ltag);
    ipos = m_find(m, itag);
    full = (m_cnt[m] == E);
    vt   = m_tag[m][E-1];
    vd   = m_dirty[m][E-1];
    vdat = m_data[m][E-1];

    e_done[m] = lv;
    e_hit[m]  = lv && (lpos >= 0);
    if (e_hit[m]) begin
      e_line[m]  = m_data[m][lpos];
      e_dirty[m] = m_dirty[m][lpos];
      tmp        = e_line[m] >> (8 * la[OB-1:0]);
      e_byte[m]  = tmp[7:0];
    end else begin
      e_line[m] = '0; e_dirty[m] = 1'b0; e_byte[m] = '0;
    end

    if (e_wbv[m] && wr) e_wbv[m] = 1'b0;

    removed = 1'b0;
    if (e_hit[m]) begin
      if (m == 1) begin
        if (!(fire && itag == ltag)) begin
          m_remove(m, lpos);
          removed = 1'b1;
        end
      end else begin
        sdat = m_data[m][lpos];
        sd   = m_dirty[m][lpos];
        m_remove(m, lpos);
        m_push(m, ltag, sdat, sd);
      end
    end

    if (fire) begin
      if (ipos >= 0) begin
        p  = m_find(m, itag);
        sd = m_dirty[m][p] | idr;
        m_remove(m, p);
        m_push(m, itag, id, sd);
      end else if (!full) begin
        m_push(m, itag, id, idr);
      end else begin
        if (!(removed && vt == ltag)) begin
          p = m_find(m, vt);
          if (vd) begin
            e_wbv[m] = 1'b1;
            e_wba[m] = {vt, {OB{1'b0}}};
            e_wbd[m] = vdat;
          end
          m_remove(m, p);
        end
        m_push(m, itag, id, idr);
      end
    end
  endtask

  // ---------------- scoreboard ----------------
  task automatic check_eq(input string tag, input logic [LB-1:0] got, input logic [LB-1:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic compare_mode(input int m, input string pfx, input logic rdy, input logic done,
                              input logic hit, input logic dirty, input logic [LB-1:0] line,
                              input logic [7:0] byte_v, input logic wbv,
                              input logic [AB-1:0] wba, input logic [LB-1:0] wbd);
    check_eq({pfx, ".ins_ready"}, rdy, !e_wbv[m]);
    check_eq({pfx, ".lk_done"}, done, e_done[m]);
    check_eq({pfx, ".lk_hit"}, hit, e_hit[m]);
    check_eq({pfx, ".lk_dirty"}, dirty, e_dirty[m]);
    check_eq({pfx, ".lk_line"}, line, e_line[m]);
    check_eq({pfx, ".lk_byte"}, byte_v, e_byte[m]);
    check_eq({pfx, ".wb_valid"}, wbv, e_wbv[m]);
    if (e_wbv[m]) begin
      check_eq({pfx, ".wb_addr"}, wba, e_wba[m]);
      check_eq({pfx, ".wb_data"}, wbd, e_wbd[m]);
    end
  endtask

  // ---------------- driver ----------------
  task automatic step(input logic r, input logic iv, input logic [AB-1:0] ia,
                      input logic [LB-1:0] id, input logic idr, input logic lv,
                      input logic [AB-1:0] la, input logic wr);
    rst = r;
    if0.ins_valid = iv; if0.ins_addr = ia; if0.ins_data = id; if0.ins_dirty = idr;
    if0.lk_valid = lv;  if0.lk_addr = la;  if0.wb_ready = wr;
    if1.ins_valid = iv; if1.ins_addr = ia; if1.ins_data = id; if1.ins_dirty = idr;
    if1.lk_valid = lv;  if1.lk_addr = la;  if1.wb_ready = wr;
    for (int m = 0; m < 2; m++) model_step(m, r, iv, ia, id, idr, lv, la, wr);
    @(posedge clk);
    #1;
    compare_mode(0, "incl", if0.ins_ready, if0.lk_done, if0.lk_hit, if0.lk_dirty, if0.lk_line,
                 if0.lk_byte, if0.wb_valid, if0.wb_addr, if0.wb_data);
    compare_mode(1, "excl", if1.ins_ready, if1.lk_done, if1.lk_hit, if1.lk_dirty, if1.lk_line,
                 if1.lk_byte, if1.wb_valid, if1.wb_addr, if1.wb_data);
  endtask

  function automatic logic [LB-1:0] pat(input logic [7:0] b);
    return {32{b}};
  endfunction

  function automatic logic [AB-1:0] line_addr(input int k);
    return AB'(k) << 24;
  endfunction

  task automatic do_reset();
    step(1'b1, 1'b0, '0, '0, 1'b0, 1'b0, '0, 1'b1);
  endtask

  task automatic ins(input int k, input logic [LB-1:0] d, input logic dr, input logic wr);
    step(1'b0, 1'b1, line_addr(k), d, dr, 1'b0, '0, wr);
  endtask

  task automatic lk(input logic [AB-1:0] a);
    step(1'b0, 1'b0, '0, '0, 1'b0, 1'b1, a, 1'b1);
  endtask

  task automatic fill4(input logic first_dirty);
    do_reset();
    for (int k = 1; k <= 4; k++) begin
      ins(k, pat({4'(k), 4'(k)}), (k == 1) ? first_dirty : 1'b0, 1'b1);
    end
  endtask

  // ---------------- main sequence ----------------
  initial begin
    logic          r, iv, idr, lv, wr;
    logic [AB-1:0] ia, la;
    logic [LB-1:0] id;
    n_checks = 0;
    n_fail   = 0;
    rst = 1'b1;
    if0.ins_valid = 1'b0; if0.lk_valid = 1'b0; if0.wb_ready = 1'b1;
    if1.ins_valid = 1'b0; if1.lk_valid = 1'b0; if1.wb_ready = 1'b1;

    // Reset state
    do_reset();
    do_reset();
    check_eq("rst.ins_ready", if1.ins_ready, 1'b1);
    check_eq("rst.wb_valid", if1.wb_valid, 1'b0);

    // Fill and hit
    fill4(1'b0);
    lk(32'h0300_0003);
    check_eq("fill.hit", if1.lk_hit, 1'b1);
    check_eq("fill.byte", if1.lk_byte, 8'h33);
    check_eq("fill.dirty", if1.lk_dirty, 1'b0);
    check_eq("fill.incl_byte", if0.lk_byte, 8'h33);
    lk(32'h0300_0003);
    check_eq("fill.excl_rehit", if1.lk_hit, 1'b0);
    check_eq("fill.incl_rehit", if0.lk_hit, 1'b1);

    // Clean eviction
    fill4(1'b0);
    ins(5, pat(8'h55), 1'b0, 1'b1);
    check_eq("clean.wb_valid", if1.wb_valid, 1'b0);
    lk(line_addr(1));
    check_eq("clean.old_miss", if1.lk_hit, 1'b0);
    lk(line_addr(5));
    check_eq("clean.new_hit", if1.lk_hit, 1'b1);

    // Dirty eviction with back-pressure; a refused insert is offered meanwhile
    fill4(1'b1);
    ins(5, pat(8'h55), 1'b0, 1'b0);
    for (int c = 0; c < 5; c++) begin
      check_eq("dirty.wb_valid", if1.wb_valid, 1'b1);
      check_eq("dirty.wb_addr", if1.wb_addr, 32'h0100_0000);
      check_eq("dirty.wb_data", if1.wb_data, pat(8'h11));
      check_eq("dirty.ins_ready", if1.ins_ready, 1'b0);
      if (c < 4) ins(6, pat(8'h66), 1'b1, 1'b0);
    end
    step(1'b0, 1'b0, '0, '0, 1'b0, 1'b0, '0, 1'b1);
    check_eq("dirty.released", if1.wb_valid, 1'b0);
    check_eq("dirty.ready_back", if1.ins_ready, 1'b1);
    lk(line_addr(6));
    check_eq("dirty.refused_miss", if1.lk_hit, 1'b0);

    // LRU update, inclusive instance
    fill4(1'b0);
    lk(line_addr(1));
    ins(5, pat(8'h55), 1'b0, 1'b1);
    lk(line_addr(2));
    check_eq("lru.b_evicted", if0.lk_hit, 1'b0);
    lk(line_addr(1));
    check_eq("lru.a_hit", if0.lk_hit, 1'b1);

    // Same-tag collision
    fill4(1'b0);
    step(1'b0, 1'b1, 32'h0200_0000, pat(8'hAA), 1'b0, 1'b1, 32'h0200_0002, 1'b1);
    check_eq("coll.old_excl", if1.lk_byte, 8'h22);
    check_eq("coll.old_incl", if0.lk_byte, 8'h22);
    lk(32'h0200_0002);
    check_eq("coll.new_excl", if1.lk_byte, 8'hAA);
    check_eq("coll.new_incl", if0.lk_byte, 8'hAA);

    // Reset mid write-back
    fill4(1'b1);
    ins(5, pat(8'h55), 1'b0, 1'b0);
    check_eq("rstwb.pending", if1.wb_valid, 1'b1);
    step(1'b1, 1'b0, '0, '0, 1'b0, 1'b0, '0, 1'b0);
    check_eq("rstwb.wb_valid", if1.wb_valid, 1'b0);
    check_eq("rstwb.ins_ready", if1.ins_ready, 1'b1);
    for (int k = 1; k <= 5; k++) begin
      lk(line_addr(k));
      check_eq("rstwb.excl_miss", if1.lk_hit, 1'b0);
      check_eq("rstwb.incl_miss", if0.lk_hit, 1'b0);
    end

    // Randomized traffic against the model
    for (int c = 0; c < 3000; c++) begin
      r   = ($urandom_range(0, 199) == 0);
      iv  = ($urandom_range(0, 1) == 1);
      ia  = line_addr($urandom_range(1, 7)) | AB'($urandom_range(0, 31));
      for (int w = 0; w < LB / 32; w++) id[w*32 +: 32] = $urandom;
      idr = ($urandom_range(0, 1) == 1);
      lv  = ($urandom_range(0, 1) == 1);
      if ($urandom_range(0, 3) == 0) begin
        la = {ia[AB-1:OB], 5'($urandom_range(0, 31))};
      end else begin
        la = line_addr($urandom_range(1, 7)) | AB'($urandom_range(0, 31));
      end
      wr  = ($urandom_range(0, 3) != 0);
      step(r, iv, ia, id, idr, lv, la, wr);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
